// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//
// Shared types for the reset sequencer.
//
// Contents:
//   state_t  - sequencer FSM state encoding (HOLD, RELEASE, RUN, ASSERT)
//   is_busy  - helper that reports whether a state counts as "busy"
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    // Sequencer FSM states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        ASSERT  = 2'd3
    } state_t;

    // The sequencer is busy whenever it is doing anything other than
    // sitting in RUN with every domain out of reset.
    function automatic logic is_busy(input state_t s);
        return (s != RUN);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
//
// Bundles the soft-reset handshake and the per-domain reset/status outputs
// of the reset sequencer.
//
// Parameters:
//   NUM_DOMAINS     - number of downstream reset domains
//
// Signals:
//   soft_rst_req_i  - soft-reset request (four-phase level handshake)
//   soft_rst_ack_o  - soft-reset acknowledge
//   domain_rst_o    - per-domain active-high reset, bit k feeds domain k
//   all_released_o  - high when every domain is out of reset
//   busy_o          - high whenever the sequencer is not in RUN
//
// Modports:
//   master - requester side (drives the request, observes everything else)
//   slave  - sequencer side
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);

    logic                   soft_rst_req_i;
    logic                   soft_rst_ack_o;
    logic [NUM_DOMAINS-1:0] domain_rst_o;
    logic                   all_released_o;
    logic                   busy_o;

    modport master (
        output soft_rst_req_i,
        input  soft_rst_ack_o,
        input  domain_rst_o,
        input  all_released_o,
        input  busy_o
    );

    modport slave (
        input  soft_rst_req_i,
        output soft_rst_ack_o,
        output domain_rst_o,
        output all_released_o,
        output busy_o
    );

endinterface

// File: rtl/reset_sequencer_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
//
// Asynchronous-assert, synchronous-deassert reset synchronizer. The chain is
// cleared the instant reset goes low; once reset is released a one is shifted
// in from the bottom, so rst_sync_n rises on the SYNC_STAGES-th rising clock
// edge after reset deasserts.
//
// Parameters:
//   SYNC_STAGES - number of flops in the chain (>= 2)
//
// Ports:
//   clk         - clock
//   reset       - asynchronous active-low reset
//   rst_sync_n  - synchronized active-low reset (high = out of reset)
// -----------------------------------------------------------------------------
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain: cleared asynchronously, fills with ones one stage per
    // clock once reset is released. Only the last stage is used, so any
    // metastability in the first stage has SYNC_STAGES-1 cycles to settle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Releases NUM_DOMAINS synchronous-reset domains in ascending index order,
// STAGGER_CYCLES clocks apart, after chip reset. From RUN it also services a
// four-phase soft-reset request: all domains are re-asserted, held for
// STAGGER_CYCLES clocks, then released again in the same staggered order,
// after which the request is acknowledged.
//
// Parameters:
//   NUM_DOMAINS     - number of downstream reset domains (>= 1)
//   STAGGER_CYCLES  - clocks between domain releases and soft-reset hold (>= 1)
//   SYNC_STAGES     - depth of the reset-deassertion synchronizer (>= 2)
//
// Ports:
//   clk             - clock, all state updates on its rising edge
//   reset           - asynchronous active-low chip reset
//   bus (slave)     - soft-reset handshake, per-domain resets and status
//
// Timing after chip reset: domain k leaves reset on rising edge
//   SYNC_STAGES + (k+1)*STAGGER_CYCLES counted from reset deassertion.
// Timing after a soft-reset request accepted on edge E: domain k leaves reset
//   on edge E + (k+2)*STAGGER_CYCLES and RUN is re-entered on edge
//   E + (NUM_DOMAINS+1)*STAGGER_CYCLES.
// -----------------------------------------------------------------------------
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int STAGGER_CYCLES = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(STAGGER_CYCLES + 1);
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q;
    logic [NUM_DOMAINS-1:0] domain_rst_d;
    logic                   soft_active_q;
    logic                   soft_active_d;
    logic                   ack_q;
    logic                   ack_d;
    logic                   release_step;
    logic                   rst_sync_n;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_n (rst_sync_n)
    );

    // State register. Chip reset forces every domain back into reset and
    // aborts any soft-reset sequence in progress without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            domain_rst_q  <= '1;
            soft_active_q <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            domain_rst_q  <= domain_rst_d;
            soft_active_q <= soft_active_d;
            ack_q         <= ack_d;
        end
    end

    // Next-state logic.
    //
    // The edge on which HOLD sees the synchronized reset already counts as
    // the first stagger cycle of the release phase. That keeps the chip-reset
    // release of domain k at SYNC_STAGES + (k+1)*STAGGER_CYCLES edges, and
    // with STAGGER_CYCLES=1 it lets domain 0 release on that very edge.
    //
    // soft_active remembers that the current release phase came from a soft
    // request, so only that path raises the acknowledge on reaching RUN.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        domain_rst_d  = domain_rst_q;
        soft_active_d = soft_active_q;
        ack_d         = ack_q;
        release_step  = 1'b0;

        case (state_q)
            HOLD: begin
                cnt_d = '0;
                idx_d = '0;
                if (rst_sync_n) begin
                    state_d      = RELEASE;
                    release_step = 1'b1;
                end
            end

            RELEASE: begin
                release_step = 1'b1;
            end

            RUN: begin
                if (ack_q) begin
                    ack_d = bus.soft_rst_req_i;
                end else if (bus.soft_rst_req_i) begin
                    state_d       = ASSERT;
                    cnt_d         = '0;
                    idx_d         = '0;
                    domain_rst_d  = '1;
                    soft_active_d = 1'b1;
                end
            end

            ASSERT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = HOLD;
            end
        endcase

        // One stagger cycle of the release phase: count, and on the last
        // count drop the reset of the current domain and move to the next.
        if (release_step) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                for (int k = 0; k < NUM_DOMAINS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        domain_rst_d[k] = 1'b0;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = RUN;
                    idx_d   = '0;
                    if (soft_active_q) begin
                        ack_d         = 1'b1;
                        soft_active_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Outputs are decoded straight from registered state.
    assign bus.domain_rst_o   = domain_rst_q;
    assign bus.soft_rst_ack_o = ack_q;
    assign bus.all_released_o = (state_q == RUN);
    assign bus.busy_o         = is_busy(state_q);

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer. dut0 uses the default parameters
// (4 domains, 8-cycle stagger, 2-stage sync); dut1 is the 1-domain,
// 1-cycle-stagger corner. Outputs are sampled 1 time unit after rising edges.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic clk;
    logic reset0;
    logic reset1;
    int   checks = 0;
    int   errors = 0;

    // Expected domain_rst_o of dut0 at chosen edges after reset deassertion.
    int         pw_edge [8] = '{9, 10, 17, 18, 25, 26, 33, 34};
    logic [3:0] pw_rst  [8] = '{4'b1111, 4'b1110, 4'b1110, 4'b1100,
                                4'b1100, 4'b1000, 4'b1000, 4'b0000};

    // Expected domain_rst_o of dut0 at chosen edges after a soft request at E.
    int         sr_edge [8] = '{15, 16, 23, 24, 31, 32, 39, 40};
    logic [3:0] sr_rst  [8] = '{4'b1111, 4'b1110, 4'b1110, 4'b1100,
                                4'b1100, 4'b1000, 4'b1000, 4'b0000};

    reset_sequencer_if #(.NUM_DOMAINS(4)) bus0 ();
    reset_sequencer_if #(.NUM_DOMAINS(1)) bus1 ();

    reset_sequencer #(
        .NUM_DOMAINS    (4),
        .STAGGER_CYCLES (8),
        .SYNC_STAGES    (2)
    ) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    reset_sequencer #(
        .NUM_DOMAINS    (1),
        .STAGGER_CYCLES (1),
        .SYNC_STAGES    (2)
    ) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Both DUTs held in reset: check the reset values.
    task automatic test_reset();
        reset0 = 1'b0;
        reset1 = 1'b0;
        bus0.soft_rst_req_i = 1'b0;
        bus1.soft_rst_req_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus0.domain_rst_o !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_domain_rst got %b exp %b", bus0.domain_rst_o, 4'b1111);
        end
        checks++;
        if (bus0.all_released_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_all_released got %b exp 0", bus0.all_released_o);
        end
        checks++;
        if (bus0.busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_busy got %b exp 1", bus0.busy_o);
        end
        checks++;
        if (bus0.soft_rst_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ack got %b exp 0", bus0.soft_rst_ack_o);
        end
    endtask

    // Release reset0 and follow the staggered power-up release of dut0.
    task automatic test_powerup();
        @(negedge clk);
        reset0 = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 8; j++) begin
                if (pw_edge[j] == e) begin
                    checks++;
                    if (bus0.domain_rst_o !== pw_rst[j]) begin
                        errors++;
                        $display("[TB] FAIL powerup_domain_rst edge %0d got %b exp %b", e, bus0.domain_rst_o, pw_rst[j]);
                    end
                    checks++;
                    if (bus0.all_released_o !== (e == 34)) begin
                        errors++;
                        $display("[TB] FAIL powerup_all_released edge %0d got %b exp %b", e, bus0.all_released_o, (e == 34));
                    end
                    checks++;
                    if (bus0.busy_o !== (e != 34)) begin
                        errors++;
                        $display("[TB] FAIL powerup_busy edge %0d got %b exp %b", e, bus0.busy_o, (e != 34));
                    end
                end
            end
        end
        checks++;
        if (bus0.soft_rst_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL powerup_ack got %b exp 0", bus0.soft_rst_ack_o);
        end
    endtask

    // Soft reset with the request held until after the acknowledge.
    task automatic test_soft_held();
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.domain_rst_o !== 4'b1111 || bus0.busy_o !== 1'b1 || bus0.all_released_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL soft_assert rst/busy/all got %b/%b/%b exp 1111/1/0",
                     bus0.domain_rst_o, bus0.busy_o, bus0.all_released_o);
        end
        for (int e = 1; e <= 42; e++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 8; j++) begin
                if (sr_edge[j] == e) begin
                    checks++;
                    if (bus0.domain_rst_o !== sr_rst[j]) begin
                        errors++;
                        $display("[TB] FAIL soft_domain_rst edge E+%0d got %b exp %b", e, bus0.domain_rst_o, sr_rst[j]);
                    end
                    checks++;
                    if (bus0.soft_rst_ack_o !== (e == 40)) begin
                        errors++;
                        $display("[TB] FAIL soft_ack edge E+%0d got %b exp %b", e, bus0.soft_rst_ack_o, (e == 40));
                    end
                    checks++;
                    if (bus0.busy_o !== (e != 40)) begin
                        errors++;
                        $display("[TB] FAIL soft_busy edge E+%0d got %b exp %b", e, bus0.busy_o, (e != 40));
                    end
                end
            end
        end
        checks++;
        if (bus0.soft_rst_ack_o !== 1'b1 || bus0.domain_rst_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL soft_ack_hold ack/rst got %b/%b exp 1/0000", bus0.soft_rst_ack_o, bus0.domain_rst_o);
        end
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.soft_rst_ack_o !== 1'b0 || bus0.busy_o !== 1'b0 || bus0.domain_rst_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL soft_ack_drop ack/busy/rst got %b/%b/%b exp 0/0/0000",
                     bus0.soft_rst_ack_o, bus0.busy_o, bus0.domain_rst_o);
        end
    endtask

    // One-cycle request: full sequence still runs, ack pulses for one cycle.
    task automatic test_short_req();
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b1;
        @(posedge clk);
        #1;
        bus0.soft_rst_req_i = 1'b0;
        checks++;
        if (bus0.domain_rst_o !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL short_assert got %b exp 1111", bus0.domain_rst_o);
        end
        for (int e = 1; e <= 42; e++) begin
            @(posedge clk);
            #1;
            if (e == 39) begin
                checks++;
                if (bus0.soft_rst_ack_o !== 1'b0 || bus0.domain_rst_o !== 4'b1000) begin
                    errors++;
                    $display("[TB] FAIL short_e39 ack/rst got %b/%b exp 0/1000", bus0.soft_rst_ack_o, bus0.domain_rst_o);
                end
            end
            if (e == 40) begin
                checks++;
                if (bus0.soft_rst_ack_o !== 1'b1 || bus0.domain_rst_o !== 4'b0000 || bus0.busy_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL short_e40 ack/rst/busy got %b/%b/%b exp 1/0000/0",
                             bus0.soft_rst_ack_o, bus0.domain_rst_o, bus0.busy_o);
                end
            end
            if (e == 41 || e == 42) begin
                checks++;
                if (bus0.soft_rst_ack_o !== 1'b0 || bus0.domain_rst_o !== 4'b0000 || bus0.busy_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL short_after edge E+%0d ack/rst/busy got %b/%b/%b exp 0/0000/0",
                             e, bus0.soft_rst_ack_o, bus0.domain_rst_o, bus0.busy_o);
                end
            end
        end
    endtask

    // Request raised and dropped during the power-up release is ignored.
    task automatic test_req_while_busy();
        @(negedge clk);
        reset0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset0 = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e == 20) bus0.soft_rst_req_i = 1'b1;
            if (e == 30) bus0.soft_rst_req_i = 1'b0;
            @(posedge clk);
            #1;
            if (e == 26) begin
                checks++;
                if (bus0.domain_rst_o !== 4'b1000 || bus0.busy_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL busy_req_e26 rst/busy got %b/%b exp 1000/1", bus0.domain_rst_o, bus0.busy_o);
                end
            end
            if (e == 34 || e == 40) begin
                checks++;
                if (bus0.domain_rst_o !== 4'b0000 || bus0.busy_o !== 1'b0 ||
                    bus0.all_released_o !== 1'b1 || bus0.soft_rst_ack_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL busy_req edge %0d rst/busy/all/ack got %b/%b/%b/%b exp 0000/0/1/0",
                             e, bus0.domain_rst_o, bus0.busy_o, bus0.all_released_o, bus0.soft_rst_ack_o);
                end
            end
        end
    endtask

    // Chip reset in the middle of a soft reset takes effect without a clock.
    task automatic test_reset_mid_sequence();
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus0.domain_rst_o !== 4'b1110 || bus0.busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midseq_e20 rst/busy got %b/%b exp 1110/1", bus0.domain_rst_o, bus0.busy_o);
        end
        #2;
        reset0 = 1'b0;
        bus0.soft_rst_req_i = 1'b0;
        #1;
        checks++;
        if (bus0.domain_rst_o !== 4'b1111 || bus0.soft_rst_ack_o !== 1'b0 ||
            bus0.busy_o !== 1'b1 || bus0.all_released_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midseq_async rst/ack/busy/all got %b/%b/%b/%b exp 1111/0/1/0",
                     bus0.domain_rst_o, bus0.soft_rst_ack_o, bus0.busy_o, bus0.all_released_o);
        end
        repeat (2) @(posedge clk);
        test_powerup();
    endtask

    // Single-domain, single-cycle-stagger corner on dut1.
    task automatic test_small_corner();
        @(negedge clk);
        reset1 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus1.domain_rst_o !== 1'b1 || bus1.busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL corner_e2 rst/busy got %b/%b exp 1/1", bus1.domain_rst_o, bus1.busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus1.domain_rst_o !== 1'b0 || bus1.busy_o !== 1'b0 || bus1.all_released_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL corner_e3 rst/busy/all got %b/%b/%b exp 0/0/1",
                     bus1.domain_rst_o, bus1.busy_o, bus1.all_released_o);
        end
        @(negedge clk);
        bus1.soft_rst_req_i = 1'b1;
        @(posedge clk);
        #1;
        bus1.soft_rst_req_i = 1'b0;
        checks++;
        if (bus1.domain_rst_o !== 1'b1 || bus1.busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL corner_soft_E rst/busy got %b/%b exp 1/1", bus1.domain_rst_o, bus1.busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus1.domain_rst_o !== 1'b1 || bus1.busy_o !== 1'b1 || bus1.soft_rst_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL corner_soft_E1 rst/busy/ack got %b/%b/%b exp 1/1/0",
                     bus1.domain_rst_o, bus1.busy_o, bus1.soft_rst_ack_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus1.domain_rst_o !== 1'b0 || bus1.busy_o !== 1'b0 || bus1.soft_rst_ack_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL corner_soft_E2 rst/busy/ack got %b/%b/%b exp 0/0/1",
                     bus1.domain_rst_o, bus1.busy_o, bus1.soft_rst_ack_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus1.soft_rst_ack_o !== 1'b0 || bus1.domain_rst_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL corner_soft_E3 ack/rst got %b/%b exp 0/0", bus1.soft_rst_ack_o, bus1.domain_rst_o);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_soft_held();
        test_short_req();
        test_req_while_busy();
        test_reset_mid_sequence();
        test_small_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Reset controller for the flop-based datapath domains. It releases up to NUM_DOMAINS downstream synchronous-reset domains in a fixed staggered order after chip reset. It also services a four-phase soft-reset request that re-asserts and re-releases all domains. It sits between the board-level asynchronous reset and the reset inputs of the downstream sync-reset flop banks.

Parameters:
NUM_DOMAINS, 4, number of downstream reset domains (>=1)
STAGGER_CYCLES, 8, clock cycles between successive domain releases; also the soft-reset hold time (>=1)
SYNC_STAGES, 2, depth of the reset-deassertion synchronizer (>=2)

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
soft_rst_req_i  input  1  soft-reset request, four-phase level handshake
soft_rst_ack_o  output  1  soft-reset acknowledge
domain_rst_o  output  NUM_DOMAINS  per-domain active-high reset, synchronous to clk once deasserted; bit k feeds domain k
all_released_o  output  1  high when every domain is out of reset
busy_o  output  1  high whenever the FSM is not in RUN

Behaviour:
- reset low, at any time or in any state, immediately forces: domain_rst_o all ones, all_released_o=0, soft_rst_ack_o=0, busy_o=1, FSM=HOLD, counters=0, synchronizer cleared.
- Synchronizer: async-assert, sync-deassert chain of SYNC_STAGES flops. rst_sync_n goes high on the SYNC_STAGES-th rising edge after reset deasserts.
- FSM states: HOLD, RELEASE, RUN, ASSERT.
- HOLD: waits for rst_sync_n=1, then moves to RELEASE with stagger counter=0 and domain index=0.
- RELEASE:
  - Stagger counter increments each cycle.
  - On the cycle it equals STAGGER_CYCLES-1, domain_rst_o[idx] clears at that edge, the counter returns to 0 and idx increments.
  - Released bits stay cleared.
  - When idx reaches NUM_DOMAINS-1 and that domain releases, the FSM enters RUN on the same edge, and all_released_o rises on that edge.
- Timing after chip reset: domain k deasserts exactly SYNC_STAGES + (k+1)*STAGGER_CYCLES rising edges after reset deassertion. Defaults give edges 10, 18, 26, 34.
- RUN:
  - busy_o=0.
  - If soft_rst_req_i=1 and soft_rst_ack_o=0 at edge E, then at edge E: domain_rst_o all ones, all_released_o=0, busy_o=1, FSM=ASSERT, counter=0.
- ASSERT: holds all domains in reset for STAGGER_CYCLES cycles, then enters RELEASE with idx=0.
  - Domain k deasserts at edge E + (k+2)*STAGGER_CYCLES.
  - Return to RUN happens at edge E + (NUM_DOMAINS+1)*STAGGER_CYCLES.
- Ack rules:
  - soft_rst_ack_o rises on the edge the FSM returns to RUN after a soft reset.
  - It stays high while soft_rst_req_i=1.
  - It falls on the first edge at which req is sampled 0. If req is already 0 at completion, ack is high for exactly one cycle.
  - A request is ignored while ack=1 or while the FSM is not in RUN. soft_rst_req_i is never latched during HOLD, RELEASE or ASSERT.
- Chip reset during a soft-reset sequence aborts it: ack=0, sequence restarts from HOLD.
- Counter widths: stagger counter is $clog2(STAGGER_CYCLES+1) bits; idx is $clog2(NUM_DOMAINS+1) bits. Both are compared at full width, with no wrap-around.
- Release order: domains always release in ascending index order.

Decomposition:
- Package rst_seq_pkg: typedef enum state_t {HOLD, RELEASE, RUN, ASSERT}, 2 bits, encodings 0..3.
- Sub-module reset_sync (parameter SYNC_STAGES): async-assert, sync-deassert synchronizer, inputs clk and reset, output rst_sync_n. The sequencer FSM, counters and handshake stay in reset_sequencer.

Test Plan:
1. Power-up, defaults: reset low 5 cycles, then high -> domain_rst_o=4'b1111 until edge 10; then 4'b1110@10, 4'b1100@18, 4'b1000@26, 4'b0000@34; all_released_o and busy_o=0 at edge 34.
2. Soft reset: in RUN, req=1 at edge E, held -> domain_rst_o=4'b1111@E; releases at E+16, E+24, E+32, E+40; ack=1@E+40; drop req -> ack=0 at next sampled edge.
3. Short request: req high 1 cycle then low -> full sequence runs; ack high exactly one cycle at E+40.
4. Request while busy: assert req during the power-up RELEASE phase (e.g. edge 20) and drop it at 30 -> no re-assertion; sequence completes at 34 and ack stays 0.
5. Reset mid-sequence: reset low at E+20 during a soft reset -> domain_rst_o=4'b1111 and ack=0 immediately, without waiting for a clock edge; after reset high, release timing matches test 1.
6. Parameter corner, NUM_DOMAINS=1, STAGGER_CYCLES=1 -> domain_rst_o[0] clears at edge SYNC_STAGES+1 = 3; soft reset returns to RUN at E+2.
